// File: rtl/fp_pkg.sv
// fp_pkg: shared FSM encoding, flag bit positions and IEEE field constants for the FP add/sub unit.
package fp_pkg;
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UDF = 1;
  localparam int FLG_INX = 0;
  function automatic logic [63:0] exp_ones(int ew);
    return (64'd1 << ew) - 64'd1;
  endfunction
  function automatic logic [63:0] exp_bias(int ew);
    return (64'd1 << (ew - 1)) - 64'd1;
  endfunction
  // {0, exponent all ones, fraction MSB set}
  function automatic logic [63:0] qnan(int ew, int mw);
    return ((64'd1 << (ew + 1)) - 64'd1) << (mw - 1);
  endfunction
endpackage

// File: rtl/fp_rne_rounder.sv
// fp_rne_rounder: round-to-nearest-even on {mant,G,R,S}, saturating to infinity on exponent overflow.
module fp_rne_rounder
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0]   mant_i,
  input  logic             g_i,
  input  logic             r_i,
  input  logic             s_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic [MAN_W-1:0] frac_o,
  output logic [EXP_W-1:0] exp_o,
  output logic             inexact_o,
  output logic             ovf_o
);
  localparam logic [EXP_W-1:0] ONES = EXP_W'(exp_ones(EXP_W));
  logic             inc;
  logic [MAN_W+1:0] sum;
  logic [EXP_W:0]   e;
  assign inc = g_i & (r_i | s_i | mant_i[0]);
  assign sum = {1'b0, mant_i} + (MAN_W+2)'(inc);
  // a carry out of the significand leaves the fraction at zero and bumps the exponent
  assign e = {1'b0, exp_i} + (EXP_W+1)'(sum[MAN_W+1]);
  assign ovf_o = e >= {1'b0, ONES};
  assign exp_o = ovf_o ? ONES : e[EXP_W-1:0];
  assign frac_o = ovf_o ? '0 : sum[MAN_W-1:0];
  assign inexact_o = g_i | r_i | s_i | ovf_o;
endmodule

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: self-sequenced IEEE-754 adder/subtractor with FTZ, special operands,
// RNE rounding and status flags, behind valid/ready handshakes.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_sub,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int F = MAN_W + 4;
  localparam logic [EXP_W-1:0] ONES = EXP_W'(exp_ones(EXP_W));
  localparam logic [W-1:0] QN = W'(qnan(EXP_W, MAN_W));
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic sb_q, sb_d, sign_q, sign_d, sub_q, sub_d, spec_q, spec_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [F:0] mant_q, mant_d, sum;
  logic [F-1:0] sml_q, sml_d;
  logic [3:0] flags_q, flags_d;
  logic [EXP_W-1:0] ea, eb, el, es, d;
  logic [MAN_W-1:0] fa, fb;
  logic za, zb, nan_a, nan_b, inf_a, inf_b, inf_inv, a_ge, sl, ss, lost;
  logic [F-1:0] ext_a, ext_b, ext_l, ext_s, sh_s;
  logic [MAN_W-1:0] r_frac;
  logic [EXP_W-1:0] r_exp;
  logic r_inx, r_ovf;
  assign ea = a_q[W-2 -: EXP_W];
  assign eb = b_q[W-2 -: EXP_W];
  assign fa = a_q[MAN_W-1:0];
  assign fb = b_q[MAN_W-1:0];
  assign za = ea == '0;
  assign zb = eb == '0;
  assign nan_a = ea == ONES && fa != '0;
  assign nan_b = eb == ONES && fb != '0;
  assign inf_a = ea == ONES && fa == '0;
  assign inf_b = eb == ONES && fb == '0;
  assign inf_inv = inf_a & inf_b & (a_q[W-1] ^ sb_q);
  // denormal inputs are flushed: their magnitude and significand count as zero
  assign a_ge = {ea, fa & {MAN_W{~za}}} >= {eb, fb & {MAN_W{~zb}}};
  assign ext_a = za ? '0 : {1'b1, fa, 3'b000};
  assign ext_b = zb ? '0 : {1'b1, fb, 3'b000};
  assign ext_l = a_ge ? ext_a : ext_b;
  assign ext_s = a_ge ? ext_b : ext_a;
  assign el = a_ge ? ea : eb;
  assign es = a_ge ? eb : ea;
  assign sl = a_ge ? a_q[W-1] : sb_q;
  assign ss = a_ge ? sb_q : a_q[W-1];
  assign d = el - es;
  assign lost = |(ext_s & ~({F{1'b1}} << d));
  assign sh_s = (32'(d) >= MAN_W + 3) ? {{(F-1){1'b0}}, |ext_s} : (ext_s >> d) | {{(F-1){1'b0}}, lost};
  assign sum = sub_q ? mant_q - {1'b0, sml_q} : mant_q + {1'b0, sml_q};
  fp_rne_rounder #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_rnd (
    .mant_i(mant_q[F-1:3]), .g_i(mant_q[2]), .r_i(mant_q[1]), .s_i(mant_q[0]), .exp_i(exp_q),
    .frac_o(r_frac), .exp_o(r_exp), .inexact_o(r_inx), .ovf_o(r_ovf)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sb_d = sb_q;
    sign_d = sign_q;
    sub_d = sub_q;
    spec_d = spec_q;
    exp_d = exp_q;
    mant_d = mant_q;
    sml_d = sml_q;
    result_d = result_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = b;
        sb_d = b[W-1] ^ op_sub;
        state_d = ALIGN;
      end
      ALIGN: begin
        sign_d = sl;
        sub_d = sl ^ ss;
        exp_d = el;
        mant_d = {1'b0, ext_l};
        sml_d = sh_s;
        spec_d = nan_a | nan_b | inf_a | inf_b;
        state_d = spec_d ? ROUND : ADD;
        if (spec_d) begin
          result_d = (nan_a | nan_b | inf_inv) ? QN : {inf_a ? a_q[W-1] : sb_q, ONES, {MAN_W{1'b0}}};
          flags_d = '0;
          flags_d[FLG_INV] = inf_inv & ~(nan_a | nan_b);
        end
      end
      ADD: begin
        mant_d = sum;
        sign_d = (sum == '0 && sub_q) ? 1'b0 : sign_q;
        exp_d = sum == '0 ? '0 : exp_q;
        state_d = NORM;
      end
      NORM: begin
        if (mant_q[F]) begin
          mant_d = {1'b0, mant_q[F:2], mant_q[1] | mant_q[0]};
          exp_d = exp_q + 1'b1;
          state_d = ROUND;
        end else if (mant_q[F-1] || mant_q == '0) begin
          state_d = ROUND;
        end else if (exp_q == EXP_W'(1)) begin
          result_d = {sign_q, {(W-1){1'b0}}};
          flags_d = '0;
          flags_d[FLG_UDF] = 1'b1;
          flags_d[FLG_INX] = 1'b1;
          state_d = DONE;
        end else begin
          // the sticky bit is replicated so R|S still records lost precision
          mant_d = {mant_q[F-1:1], mant_q[0], mant_q[0]};
          exp_d = exp_q - 1'b1;
        end
      end
      ROUND: begin
        state_d = DONE;
        if (!spec_q) begin
          result_d = {sign_q, r_exp, r_frac};
          flags_d = '0;
          flags_d[FLG_OVF] = r_ovf;
          flags_d[FLG_INX] = r_inx;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sb_q <= 1'b0;
      sign_q <= 1'b0;
      sub_q <= 1'b0;
      spec_q <= 1'b0;
      exp_q <= '0;
      mant_q <= '0;
      sml_q <= '0;
      result_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sb_q <= sb_d;
      sign_q <= sign_d;
      sub_q <= sub_d;
      spec_q <= spec_d;
      exp_q <= exp_d;
      mant_q <= mant_d;
      sml_q <= sml_d;
      result_q <= result_d;
      flags_q <= flags_d;
    end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result = result_q;
  assign flags = flags_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: vector table plus stall and mid-operation reset sequences, scoreboard-checked.
module tb_fp_addsub_seq;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, op_sub = 0, out_ready = 1;
  logic [31:0] a = 0, b = 0;
  logic in_ready, out_valid;
  logic [31:0] result;
  logic [3:0] flags;
  int n_cmp = 0, n_bad = 0;
  vec_t vt [0:16];
  vec_t sb[$];
  vec_t e;
  fp_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic run(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    check($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
    a = v.a;
    b = v.b;
    op_sub = v.sub;
    in_valid = 1;
    @(posedge clk);
    sb.push_back(v);
    #1 in_valid = 0;
    wait_out(lat);
    e = sb.pop_front();
    check($sformatf("v%0d_lat", idx), 32'(lat), 32'(e.lat));
    check($sformatf("v%0d_res", idx), result, e.res);
    check($sformatf("v%0d_flg", idx), 32'(flags), 32'(e.flg));
    @(posedge clk);
    #1;
  endtask
  initial begin
    int lat;
    vt = '{
      '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0, 4},
      '{32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 4'h0, 6},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5, 4},
      '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8, 2},
      '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1, 4},
      '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1, 4},
      '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0, 2},
      '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0, 2},
      '{32'h40000000, 32'h40000000, 1'b1, 32'h00000000, 4'h0, 4},
      '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0, 4},
      '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0, 4},
      '{32'h3F800000, 32'hBFC00000, 1'b0, 32'hBF000000, 4'h0, 5},
      '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 4'h1, 4},
      '{32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 4'h1, 5},
      '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h3, 3},
      '{32'h01000001, 32'h01000000, 1'b1, 32'h00000000, 4'h3, 4},
      '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 4'h0, 2}
    };
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_result", result, 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 17; i++) run(vt[i], i);
    // held result while the consumer stalls; new requests must be ignored
    out_ready = 0;
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h40000000;
    op_sub = 0;
    in_valid = 1;
    @(posedge clk);
    sb.push_back(vt[0]);
    #1 in_valid = 0;
    wait_out(lat);
    e = sb.pop_front();
    check("stall_lat", 32'(lat), 32'(e.lat));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 32'h7F800000;
      b = 32'h3F800000;
      in_valid = 1;
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_res", i), result, e.res);
      check($sformatf("stall%0d_flg", i), 32'(flags), 32'(e.flg));
      check($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("stall%0d_out_valid", i), 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1 check("no_ghost_op", 32'(out_valid), 32'd0);
    // asynchronous reset while normalising
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h3F400000;
    op_sub = 1;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(posedge clk);
    #2 check("pre_rst_busy", 32'(in_ready), 32'd0);
    rst_n = 0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1;
    repeat (8) @(posedge clk);
    #1 check("aborted_no_output", 32'(out_valid), 32'd0);
    run(vt[1], 100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
